uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   UART receiver for the SerialCommunication link (8N1, LSB first, idle-high line).
//   Oversamples the asynchronous rx pin, validates the start bit, and majority-votes each bit.
//   Delivers one byte per frame on rx_msg with a 1-cycle rx_complete strobe.
//   Counterpart of the UART transmit path; the top level instantiates it on the rx pin.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD        115200      line rate, bit/s
//   OVERSAMPLE  16          samples per bit; must be >= 8 and even
//   DIV         CLK_FREQ/(BAUD*OVERSAMPLE) (=27)  derived; clocks per sample tick; integer division truncates
// PORTS
//   clk_50M      in   1  system clock; all logic on rising edge
//   rst_n        in   1  asynchronous reset, active low
//   rx           in   1  serial input, asynchronous to clk_50M, idle high
//   rx_msg       out  8  last correctly framed byte; held until the next good frame
//   rx_complete  out  1  1-cycle pulse: rx_msg has just been updated
//   frame_err    out  1  1-cycle pulse: stop bit sampled low; byte discarded
//   rx_busy      out  1  high while the FSM is not in IDLE
// BEHAVIOUR
//   Reset: async, active low; release is synchronous to clk_50M.
//     rx_msg=8'h00, rx_complete=0, frame_err=0, rx_busy=0.
//     FSM=IDLE; counters cleared; both synchroniser flops set to 1.
//   Input path: 2-flop synchroniser (rx_s); falling edge = rx_s previous 1, current 0.
//   Tick generator: counter 0..DIV-1, one tick per wrap. Held at 0 in IDLE; restarts on start detect.
//   Within each bit, tick index s counts 0..OVERSAMPLE-1.
//     Samples are taken at s = OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
//     Bit value = majority of the 3 samples, decided at s = OVERSAMPLE/2+1.
//   FSM:
//     IDLE  -> START on falling edge of rx_s.
//     START -> IDLE if voted start bit = 1 (glitch; no output pulse).
//              DATA at s = OVERSAMPLE-1 if voted start bit = 0.
//     DATA  -> shift voted bit into bit[i], i = 0..7 (LSB first).
//              STOP after bit 7 completes (s = OVERSAMPLE-1).
//     STOP  -> at the stop-bit decision tick, go to IDLE and:
//              voted 1: rx_msg <= shift register; rx_complete = 1 for the next cycle.
//              voted 0: frame_err = 1 for the next cycle; rx_msg unchanged.
//   IDLE is re-entered at mid-stop-bit, so a start edge half a bit later is caught (back-to-back frames).
//   After frame_err the line may still be low: no new start until a 1->0 edge is seen on rx_s.
//   rx_complete and frame_err are never high together. Each frame produces at most one pulse.
//   Edges during START/DATA/STOP are ignored; the bit timing is not resynchronised mid-frame.
//   Latency: falling edge on rx -> rx_complete is 2 sync clocks + (9*OVERSAMPLE + OVERSAMPLE/2+1)*DIV + 1 clocks.
//     With defaults: 2 + 153*27 + 1 = 4134 clocks (+/-1).
//   Reset asserted mid-frame: immediate return to reset values; no pulse for the partial byte.
//   Tolerance: majority sampling accepts baud mismatch up to about +/-3%.
// TESTING  (defaults; one bit = 16*27 = 432 clocks; bench drives rx with the same bit time)
//   1. Drive frame 8'hF0 -> exactly one rx_complete pulse; rx_msg=8'hF0; frame_err stays 0.
//   2. Low glitch on idle rx, 100 clocks -> FSM back to IDLE; no rx_complete, no frame_err; rx_msg unchanged.
//   3. Frame 8'h55, then frame 8'hAA with the stop bit forced 0 ->
//      rx_msg=8'h55 after the first; second gives one frame_err pulse and rx_msg stays 8'h55.
//   4. Back-to-back frames 8'h00 then 8'hFF, no idle gap -> two rx_complete pulses;
//      rx_msg=8'h00 then 8'hFF.
//   5. Assert rst_n low during bit 4 of 8'hA5, release, then send 8'h3C ->
//      no pulse for 8'hA5; rx_msg=8'h3C.
//   6. Loopback from the UART transmitter, 10 bytes 8'hF0 ->
//      10 rx_complete pulses, each with rx_msg=8'hF0; bench self-checks each byte.

Source files
------------

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART receiver, 8N1, LSB first, idle-high line.
//   The asynchronous rx pin passes through a two-flop synchroniser. A falling
//   edge in IDLE starts a frame. From then on, the frame is timed by a sample
//   tick generator that produces OVERSAMPLE ticks per bit. Each bit is decided
//   by a majority vote of three samples taken around the middle of the bit.
//   A good stop bit updates rx_msg and pulses rx_complete. A low stop bit
//   pulses frame_err and the byte is discarded.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   BAUD        line rate in bit/s
//   OVERSAMPLE  sample ticks per bit (>= 8, even)
//   DIV         clocks per sample tick = CLK_FREQ/(BAUD*OVERSAMPLE), truncated
//
// Ports
//   clk_50M      in   system clock, rising edge
//   rst_n        in   asynchronous reset, active low
//   rx           in   serial input, asynchronous, idle high
//   rx_msg       out  last correctly framed byte, held until the next good frame
//   rx_complete  out  one-cycle pulse when rx_msg has just been updated
//   frame_err    out  one-cycle pulse when the stop bit was voted low
//   rx_busy      out  high while a frame is being received (FSM not IDLE)
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_msg,
   output logic       rx_complete,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int S_W   = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
   localparam logic [S_W-1:0]   S_SAMP0  = S_W'(OVERSAMPLE/2 - 1);
   localparam logic [S_W-1:0]   S_SAMP1  = S_W'(OVERSAMPLE/2);
   localparam logic [S_W-1:0]   S_DECIDE = S_W'(OVERSAMPLE/2 + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [1:0]       r_sync;       // [0] first stage, [1] synchronised rx_s
   logic             r_rx_prev;    // rx_s delayed one clock, for edge detect
   logic [DIV_W-1:0] r_div_cnt;
   logic [S_W-1:0]   r_s_cnt;      // index of the most recent sample tick
   logic [1:0]       r_samp;       // first two of the three mid-bit samples
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic [7:0]       r_rx_msg;
   logic             r_rx_complete;
   logic             r_frame_err;

   logic             w_rx_s;
   logic             w_fall;
   logic             w_tick;
   logic [S_W-1:0]   w_s_now;
   logic             w_vote;
   logic             w_decide;
   logic             w_bit_end;
   logic             w_shift_en;
   logic             w_bit_inc;
   logic             w_load_msg;
   logic             w_frame_bad;

   // ---------------------------------------------------------------------
   // Input synchroniser and falling-edge detect
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= 2'b11;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync    <= {r_sync[0], rx};
         r_rx_prev <= r_sync[1];
      end
   end

   assign w_rx_s = r_sync[1];
   assign w_fall = r_rx_prev & ~w_rx_s;

   // ---------------------------------------------------------------------
   // Sample timing
   // The start-detect moment counts as tick 0 of the start bit. Each later
   // tick advances the index. Actions are keyed on the index the tick moves
   // to (w_s_now), so the samples at OVERSAMPLE/2-1 .. OVERSAMPLE/2+1 bracket
   // the bit centre.
   // ---------------------------------------------------------------------
   assign w_tick    = (r_state != ST_IDLE) && (r_div_cnt == DIV_LAST);
   assign w_s_now   = (r_s_cnt == S_LAST) ? '0 : r_s_cnt + 1'b1;
   assign w_decide  = w_tick && (w_s_now == S_DECIDE);
   assign w_bit_end = w_tick && (w_s_now == S_LAST);

   // Majority of the two stored samples and the live third sample.
   assign w_vote = (r_samp[0] & r_samp[1]) |
                   (r_samp[0] & w_rx_s)    |
                   (r_samp[1] & w_rx_s);

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_shift_en   = 1'b0;
      w_bit_inc    = 1'b0;
      w_load_msg   = 1'b0;
      w_frame_bad  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_fall) begin
               w_state_next = ST_START;
            end
         end

         ST_START: begin
            // A start bit that votes high was a glitch: drop it silently.
            if (w_decide && w_vote) begin
               w_state_next = ST_IDLE;
            end else if (w_bit_end) begin
               w_state_next = ST_DATA;
            end
         end

         ST_DATA: begin
            if (w_decide) begin
               w_shift_en = 1'b1;
            end
            if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
                  w_state_next = ST_STOP;
               end else begin
                  w_bit_inc = 1'b1;
               end
            end
         end

         ST_STOP: begin
            // Leave at mid-stop-bit so a back-to-back start edge is not missed.
            if (w_decide) begin
               w_state_next = ST_IDLE;
               if (w_vote) begin
                  w_load_msg = 1'b1;
               end else begin
                  w_frame_bad = 1'b1;
               end
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath: tick counters, samples, shift register, outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt     <= '0;
         r_s_cnt       <= '0;
         r_samp        <= 2'b00;
         r_bit_idx     <= 3'd0;
         r_shift       <= 8'h00;
         r_rx_msg      <= 8'h00;
         r_rx_complete <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_rx_complete <= w_load_msg;
         r_frame_err   <= w_frame_bad;

         if (w_load_msg) begin
            r_rx_msg <= r_shift;
         end

         // In IDLE the counters stay at 0. The frame timing then starts
         // fresh on the clock where START is entered.
         if (r_state == ST_IDLE) begin
            r_div_cnt <= '0;
            r_s_cnt   <= '0;
         end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            r_s_cnt   <= w_s_now;
         end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
         end

         if (w_tick && (w_s_now == S_SAMP0)) begin
            r_samp[0] <= w_rx_s;
         end
         if (w_tick && (w_s_now == S_SAMP1)) begin
            r_samp[1] <= w_rx_s;
         end

         // LSB arrives first, so shift right: after eight bits the
         // first-received bit sits at position 0.
         if (w_shift_en) begin
            r_shift <= {w_vote, r_shift[7:1]};
         end

         if (r_state != ST_DATA) begin
            r_bit_idx <= 3'd0;
         end else if (w_bit_inc) begin
            r_bit_idx <= r_bit_idx + 1'b1;
         end
      end
   end

   assign rx_msg      = r_rx_msg;
   assign rx_complete = r_rx_complete;
   assign frame_err   = r_frame_err;
   assign rx_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Self-checking bench for uart_rx_core. The clock frequency is scaled so
//   that DIV = 6, giving one bit = 16*6 = 96 clocks. Every received event
//   (rx_complete / frame_err) is logged by a monitor. Each frame's event is
//   then compared with the outcome expected from the frame that was driven.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

   localparam int TB_BAUD     = 115200;
   localparam int TB_OS       = 16;
   localparam int TB_DIV      = 6;
   localparam int TB_CLK_FREQ = TB_BAUD * TB_OS * TB_DIV;
   localparam int BIT         = TB_OS * TB_DIV;
   localparam int LATENCY     = 2 + (9*TB_OS + TB_OS/2 + 1) * TB_DIV + 1;

   localparam int EV_DONE = 1;
   localparam int EV_ERR  = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] rx_msg;
   logic       rx_complete;
   logic       frame_err;
   logic       rx_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t_fall   = 0;
   int both_cnt = 0;

   int         ev_kind[$];
   logic [7:0] ev_msg[$];
   int         ev_cyc[$];

   typedef struct {
      logic [7:0] data;
      bit         stop_b;
      int         gap_bits;
      int         exp_kind;
      logic [7:0] exp_msg;
   } vec_t;

   vec_t vecs[5];

   uart_rx_core #(
      .CLK_FREQ   (TB_CLK_FREQ),
      .BAUD       (TB_BAUD),
      .OVERSAMPLE (TB_OS)
   ) dut (
      .clk_50M     (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .rx_msg      (rx_msg),
      .rx_complete (rx_complete),
      .frame_err   (frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rx_complete && frame_err) both_cnt++;
      if (rx_complete) begin
         ev_kind.push_back(EV_DONE);
         ev_msg.push_back(rx_msg);
         ev_cyc.push_back(cyc);
      end else if (frame_err) begin
         ev_kind.push_back(EV_ERR);
         ev_msg.push_back(rx_msg);
         ev_cyc.push_back(cyc);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   // Wait n rising edges, then step 1 time unit off the edge.
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_events();
      ev_kind.delete();
      ev_msg.delete();
      ev_cyc.delete();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_b, input int bclk);
      t_fall = cyc;
      rx = 1'b0;
      wait_clks(bclk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clks(bclk);
      end
      rx = stop_b;
      wait_clks(bclk);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      wait_clks(n * BIT);
   endtask

   // Exactly one event must have been logged for the frame just sent.
   task automatic check_event(input string name, input int exp_kind, input logic [7:0] exp_msg);
      int kind;
      logic [7:0] msg;
      check({name, " event_count"}, ev_kind.size(), 1);
      if (ev_kind.size() > 0) begin
         kind = ev_kind[0];
         msg  = ev_msg[0];
         check({name, " event_kind"}, kind, exp_kind);
         if (exp_kind == EV_DONE) check({name, " event_msg"}, int'(msg), int'(exp_msg));
      end
      check({name, " rx_msg"}, int'(rx_msg), int'(exp_msg));
      $display("frame %s: kind=%0d rx_msg=0x%02h", name, kind, rx_msg);
      clear_events();
   endtask

   initial begin
      logic [7:0] last_good;
      logic [7:0] d;
      bit         sb;
      int         bclk;
      int         gap;
      int         lat;

      vecs[0] = '{8'hF0, 1'b1, 1, EV_DONE, 8'hF0};
      vecs[1] = '{8'h55, 1'b1, 1, EV_DONE, 8'h55};
      vecs[2] = '{8'hAA, 1'b0, 1, EV_ERR,  8'h55};
      vecs[3] = '{8'h00, 1'b1, 0, EV_DONE, 8'h00};
      vecs[4] = '{8'hFF, 1'b1, 1, EV_DONE, 8'hFF};

      // Reset state
      rst_n = 1'b0;
      rx    = 1'b1;
      wait_clks(5);
      check("reset rx_msg", int'(rx_msg), 0);
      check("reset rx_busy", int'(rx_busy), 0);
      check("reset rx_complete", int'(rx_complete), 0);
      check("reset frame_err", int'(frame_err), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_clks(2 * BIT);
      clear_events();

      // Table-driven frames: single good frame, good then bad stop,
      // back-to-back 00 / FF.
      for (int v = 0; v < 5; v++) begin
         send_frame(vecs[v].data, vecs[v].stop_b, BIT);
         check_event($sformatf("vec%0d", v), vecs[v].exp_kind, vecs[v].exp_msg);
         if (vecs[v].gap_bits > 0) idle_bits(vecs[v].gap_bits);
      end
      last_good = 8'hFF;

      // Short low glitch on the idle line: no event, FSM returns to IDLE.
      rx = 1'b0;
      wait_clks(BIT / 4);
      rx = 1'b1;
      wait_clks(6);
      check("glitch busy_during", int'(rx_busy), 1);
      wait_clks(2 * BIT);
      check("glitch busy_after", int'(rx_busy), 0);
      check("glitch event_count", ev_kind.size(), 0);
      check("glitch rx_msg", int'(rx_msg), int'(last_good));
      $display("glitch: events=%0d rx_msg=0x%02h", ev_kind.size(), rx_msg);
      clear_events();

      // Reset in the middle of bit 4 of 8'hA5, then a clean 8'h3C.
      d  = 8'hA5;
      rx = 1'b0;
      wait_clks(BIT);
      for (int i = 0; i < 4; i++) begin
         rx = d[i];
         wait_clks(BIT);
      end
      rx = d[4];
      wait_clks(BIT / 2);
      rst_n = 1'b0;
      wait_clks(3);
      check("midreset rx_msg", int'(rx_msg), 0);
      check("midreset rx_busy", int'(rx_busy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_bits(2);
      check("midreset event_count", ev_kind.size(), 0);
      $display("midreset: events=%0d rx_msg=0x%02h", ev_kind.size(), rx_msg);
      clear_events();
      send_frame(8'h3C, 1'b1, BIT);
      check_event("after_reset_3C", EV_DONE, 8'h3C);
      last_good = 8'h3C;
      idle_bits(1);

      // Latency from the rx falling edge to rx_complete.
      send_frame(8'h81, 1'b1, BIT);
      lat = (ev_cyc.size() > 0) ? (ev_cyc[0] - t_fall) : -1;
      if (lat >= LATENCY - 1 && lat <= LATENCY + 1) lat = LATENCY;
      check("latency", lat, LATENCY);
      check_event("latency_81", EV_DONE, 8'h81);
      last_good = 8'h81;
      idle_bits(1);

      // Loopback-style burst: 10 back-to-back 8'hF0 frames.
      for (int k = 0; k < 10; k++) begin
         send_frame(8'hF0, 1'b1, BIT);
         check_event($sformatf("loop%0d", k), EV_DONE, 8'hF0);
      end
      last_good = 8'hF0;
      idle_bits(1);

      // Randomised frames with small bit-time error against a reference
      // model: a good stop bit delivers the byte; a bad stop bit leaves the
      // last good byte in place.
      for (int k = 0; k < 12; k++) begin
         d    = 8'($urandom);
         sb   = ($urandom_range(0, 4) != 0);
         bclk = BIT + $urandom_range(0, 4) - 2;
         gap  = sb ? $urandom_range(0, 2) : $urandom_range(1, 2);
         send_frame(d, sb, bclk);
         if (sb) last_good = d;
         check_event($sformatf("rand%0d_%02h_s%0d_b%0d", k, d, sb, bclk),
                     sb ? EV_DONE : EV_ERR, last_good);
         if (gap > 0) idle_bits(gap);
      end
      idle_bits(1);

      check("complete_and_err_overlap", both_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
